// File: rtl/gt_seq_pkg.sv
// Shared definitions for the GT reference-clock bring-up sequencer.
// Contents: state codes (3 bits, IDLE..FAULT), counter widths, saturating increment helper.
// No logic, no latency, no flow control.
package gt_seq_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLK_CHECK = 3'd1;
  localparam logic [2:0] S_PLL_RST   = 3'd2;
  localparam logic [2:0] S_PLL_WAIT  = 3'd3;
  localparam logic [2:0] S_GT_RST    = 3'd4;
  localparam logic [2:0] S_GT_WAIT   = 3'd5;
  localparam logic [2:0] S_READY     = 3'd6;
  localparam logic [2:0] S_FAULT     = 3'd7;

  localparam int CNT_W = 16;
  localparam int TMO_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_CLK_CHECK = S_CLK_CHECK,
    ST_PLL_RST   = S_PLL_RST,
    ST_PLL_WAIT  = S_PLL_WAIT,
    ST_GT_RST    = S_GT_RST,
    ST_GT_WAIT   = S_GT_WAIT,
    ST_READY     = S_READY,
    ST_FAULT     = S_FAULT
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer into clk; 2 clk latency; no flow control.
// Ports: clk, rst (async, active high, clears both flops to 0), d (async in), q (synced out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gt_refclk_sequencer.sv
// GT quad bring-up: refclk rate check -> PLL reset/lock -> GT TX/RX reset/done -> ready,
// with per-stage timeouts, bounded retries and a sticky fault. Outputs follow the state 1 clk late;
// async inputs see 2 clk of synchronizer latency. No flow control; enable low forces IDLE.
// Ports: clk, rst (async high); enable; refclk_tgl, pll_lock, tx_resetdone, rx_resetdone (async);
//        pll_reset, gt_tx_reset, gt_rx_reset, ready, fault, retry_cnt[1:0], state[2:0], refclk_cnt[15:0].
// Option: define GT_SEQ_LOSS_MON_EN to keep watching refclk rate and PLL lock while READY.
module gt_refclk_sequencer
  import gt_seq_pkg::*;
#(
  parameter logic [15:0] MEAS_WINDOW  = 16'd50000,
  parameter logic [15:0] REF_MIN      = 16'd15000,
  parameter logic [15:0] REF_MAX      = 16'd17000,
  parameter logic [7:0]  RST_PULSE    = 8'd16,
  parameter logic [19:0] LOCK_TIMEOUT = 20'd500000,
  parameter logic [1:0]  MAX_RETRY    = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        refclk_tgl,
  input  logic        pll_lock,
  input  logic        tx_resetdone,
  input  logic        rx_resetdone,
  output logic        pll_reset,
  output logic        gt_tx_reset,
  output logic        gt_rx_reset,
  output logic        ready,
  output logic        fault,
  output logic [1:0]  retry_cnt,
  output logic [2:0]  state,
  output logic [15:0] refclk_cnt
);

  logic tgl_s, tgl_d, lock_s, txd_s, rxd_s;

  sync_2ff u_sync_tgl  (.clk(clk), .rst(rst), .d(refclk_tgl),   .q(tgl_s));
  sync_2ff u_sync_lock (.clk(clk), .rst(rst), .d(pll_lock),     .q(lock_s));
  sync_2ff u_sync_txd  (.clk(clk), .rst(rst), .d(tx_resetdone), .q(txd_s));
  sync_2ff u_sync_rxd  (.clk(clk), .rst(rst), .d(rx_resetdone), .q(rxd_s));

  state_t                 state_q, state_d;
  logic [1:0]             retry_q, retry_d;
  logic [CNT_W-1:0]       win_q, edge_q, edge_total;
  logic [TMO_W-1:0]       tmr_q;
  logic                   edge_now, measuring, win_end, in_range;
  logic                   pulse_done, tmo, fail, fail_refclk;

  // The toggle flips once per ODIV2 cycle, so every change is one counted edge.
  assign edge_now = tgl_s ^ tgl_d;

`ifdef GT_SEQ_LOSS_MON_EN
  assign measuring = (state_q == ST_CLK_CHECK) || (state_q == ST_READY);
`else
  assign measuring = (state_q == ST_CLK_CHECK);
`endif

  assign win_end    = measuring && (win_q == MEAS_WINDOW - CNT_W'(1));
  // Include the edge seen in the final window cycle.
  assign edge_total = sat_inc(edge_q, edge_now);
  assign in_range   = (edge_total >= REF_MIN) && (edge_total <= REF_MAX);
  assign pulse_done = (tmr_q == TMO_W'(RST_PULSE - 8'd1));
  assign tmo        = (tmr_q == LOCK_TIMEOUT - TMO_W'(1));

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    fail        = 1'b0;
    fail_refclk = 1'b0;
    case (state_q)
      ST_IDLE: begin
        retry_d = '0;
        state_d = ST_CLK_CHECK;
      end
      ST_CLK_CHECK: begin
        if (win_end) begin
          if (in_range) begin
            state_d = ST_PLL_RST;
          end else begin
            fail        = 1'b1;
            fail_refclk = 1'b1;
          end
        end
      end
      ST_PLL_RST: begin
        if (pulse_done) state_d = ST_PLL_WAIT;
      end
      ST_PLL_WAIT: begin
        // Lock checked first so a lock landing on the timeout cycle still wins.
        if (lock_s)   state_d = ST_GT_RST;
        else if (tmo) fail = 1'b1;
      end
      ST_GT_RST: begin
        if (!lock_s)         fail = 1'b1;
        else if (pulse_done) state_d = ST_GT_WAIT;
      end
      ST_GT_WAIT: begin
        if (!lock_s)              fail = 1'b1;
        else if (txd_s && rxd_s)  state_d = ST_READY;
        else if (tmo)             fail = 1'b1;
      end
      ST_READY: begin
`ifdef GT_SEQ_LOSS_MON_EN
        if (win_end && !in_range) begin
          fail        = 1'b1;
          fail_refclk = 1'b1;
        end else if (!lock_s) begin
          fail = 1'b1;
        end
`endif
      end
      ST_FAULT: begin
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d = ST_IDLE;
    end else if (fail) begin
      retry_d = retry_q + 2'd1;
      if (retry_q == MAX_RETRY - 2'd1) state_d = ST_FAULT;
      else                             state_d = fail_refclk ? ST_CLK_CHECK : ST_PLL_RST;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      retry_q    <= '0;
      tgl_d      <= 1'b0;
      win_q      <= '0;
      edge_q     <= '0;
      tmr_q      <= '0;
      refclk_cnt <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      tgl_d   <= tgl_s;
      // Both measurement counters idle at zero outside measuring states and
      // restart together at each window boundary.
      if (!measuring || win_end) begin
        win_q  <= '0;
        edge_q <= '0;
      end else begin
        win_q  <= win_q + CNT_W'(1);
        edge_q <= edge_total;
      end
      if (win_end) refclk_cnt <= edge_total;
      // Shared pulse/timeout timer: zero on the first cycle of every state.
      tmr_q <= (state_d != state_q) ? '0 : tmr_q + TMO_W'(1);
    end
  end

  // Reset outputs preset to 1 so an rst assertion can only drive them high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pll_reset   <= 1'b1;
      gt_tx_reset <= 1'b1;
      gt_rx_reset <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      pll_reset   <= !((state_q == ST_PLL_WAIT) || (state_q == ST_GT_RST) ||
                       (state_q == ST_GT_WAIT)  || (state_q == ST_READY));
      gt_tx_reset <= !((state_q == ST_GT_WAIT) || (state_q == ST_READY));
      gt_rx_reset <= !((state_q == ST_GT_WAIT) || (state_q == ST_READY));
      ready       <= (state_q == ST_READY);
      fault       <= (state_q == ST_FAULT);
    end
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_gt_refclk_sequencer.sv
// Self-checking bench for gt_refclk_sequencer with small timing parameters.
// Expected output snapshots (and the clk spacing between them) are queued per scenario;
// a monitor compares each observed output change against the queue head.
module tb_gt_refclk_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        refclk_tgl = 1'b0;
  logic        pll_lock = 1'b0;
  logic        tx_resetdone = 1'b0;
  logic        rx_resetdone = 1'b0;
  logic        pll_reset, gt_tx_reset, gt_rx_reset, ready, fault;
  logic [1:0]  retry_cnt;
  logic [2:0]  state;
  logic [15:0] refclk_cnt;

  always #5 clk = ~clk;

  gt_refclk_sequencer #(
    .MEAS_WINDOW(16'd64), .REF_MIN(16'd20), .REF_MAX(16'd40),
    .RST_PULSE(8'd4), .LOCK_TIMEOUT(20'd100), .MAX_RETRY(2'd3)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .refclk_tgl(refclk_tgl),
    .pll_lock(pll_lock), .tx_resetdone(tx_resetdone), .rx_resetdone(rx_resetdone),
    .pll_reset(pll_reset), .gt_tx_reset(gt_tx_reset), .gt_rx_reset(gt_rx_reset),
    .ready(ready), .fault(fault), .retry_cnt(retry_cnt), .state(state), .refclk_cnt(refclk_cnt)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [1:0]  rc;
    logic        rdy;
    logic        flt;
    logic        pr;
    logic        tr;
    logic        rr;
    logic [15:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   dwell_q[$];
  bit   dc_q[$];
  int   tag_q[$];
  obs_t cur;
  bit   cnt_dc = 1'b0;
  int   tag_n = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Stimulus knobs for the environment models.
  int mode = 0;       // 0 dead refclk, 1 toggle every 2 clk, 2 50 toggles per 64 clk
  bit lock_ok = 1'b1;

  task automatic push(input int dw);
    exp_q.push_back(cur);
    dwell_q.push_back(dw);
    dc_q.push_back(cnt_dc);
    tag_q.push_back(tag_n);
    tag_n++;
  endtask

  task automatic drain(input int lim);
    int i = 0;
    while (exp_q.size() != 0 && i < lim) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected events pending (next ev%0d) after %0d cycles, required 0",
               exp_q.size(), tag_q[0], lim);
      exp_q.delete();
      dwell_q.delete();
      dc_q.delete();
      tag_q.delete();
    end
  endtask

  // which: 0 = pll_reset, 1 = gt_tx_reset
  task automatic wait_for(input int which, input logic val, input int lim);
    bit hit = 1'b0;
    for (int i = 0; i < lim && !hit; i++) begin
      @(negedge clk);
      if (((which == 0) ? pll_reset : gt_tx_reset) === val) hit = 1'b1;
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_for sig%0d: never reached %0b within %0d cycles", which, val, lim);
    end
  endtask

  task automatic go_idle();
    cur.st = 3'd0;
    push(-1);
    cur.rc  = 2'd0;
    cur.rdy = 1'b0;
    cur.flt = 1'b0;
    cur.pr  = 1'b1;
    cur.tr  = 1'b1;
    cur.rr  = 1'b1;
    push(1);
    enable = 1'b0;
    drain(50);
  endtask

  task automatic push_to_ready();
    cur.st = 3'd1;               push(-1);
    cur.st = 3'd2; cur.cnt = 16'd32; push(64);
    cur.st = 3'd3;               push(4);
    cur.pr = 1'b0;               push(1);
    cur.st = 3'd4;               push(-1);
    cur.st = 3'd5;               push(4);
    cur.tr = 1'b0; cur.rr = 1'b0; push(1);
    cur.st = 3'd6;               push(-1);
    cur.rdy = 1'b1;              push(1);
  endtask

  // Refclk toggle source; each pattern is 64-periodic so every window sees a fixed count.
  initial begin : refclk_gen
    int k = 0;
    forever begin
      @(negedge clk);
      k = (k + 1) % 64;
      if (mode == 1 && k[0])   refclk_tgl = ~refclk_tgl;
      if (mode == 2 && k < 50) refclk_tgl = ~refclk_tgl;
    end
  end

  // PLL model: lock 10 clk after pll_reset falls, while lock_ok holds.
  initial begin : pll_model
    int c = 0;
    forever begin
      @(negedge clk);
      if (pll_reset !== 1'b0) begin
        c = 0;
        pll_lock = 1'b0;
      end else if (c < 10) begin
        c++;
      end else begin
        pll_lock = lock_ok;
      end
    end
  end

  // GT model: resetdone 20 clk after GT reset falls.
  initial begin : gt_model
    int c = 0;
    forever begin
      @(negedge clk);
      if (gt_tx_reset !== 1'b0) begin
        c = 0;
        tx_resetdone = 1'b0;
        rx_resetdone = 1'b0;
      end else if (c < 20) begin
        c++;
      end else begin
        tx_resetdone = 1'b1;
        rx_resetdone = 1'b1;
      end
    end
  end

  initial begin : monitor
    obs_t o, last, e, m;
    int   cyc = 0;
    int   last_cyc = 0;
    int   dw, tg;
    bit   dc;
    bit   first = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      o = {state, retry_cnt, ready, fault, pll_reset, gt_tx_reset, gt_rx_reset, refclk_cnt};
      if (first || o !== last) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: got st=%0d rc=%0d rdy=%0b flt=%0b rst=%b%b%b cnt=%0d, required no change",
                   o.st, o.rc, o.rdy, o.flt, o.pr, o.tr, o.rr, o.cnt);
        end else begin
          e  = exp_q.pop_front();
          dw = dwell_q.pop_front();
          dc = dc_q.pop_front();
          tg = tag_q.pop_front();
          m  = '1;
          if (dc) m.cnt = '0;
          if (((o & m) !== (e & m)) || (dw >= 0 && (cyc - last_cyc) != dw)) begin
            n_bad++;
            $display("FAIL ev%0d: got st=%0d rc=%0d rdy=%0b flt=%0b rst=%b%b%b cnt=%0d after %0d clk; required st=%0d rc=%0d rdy=%0b flt=%0b rst=%b%b%b cnt=%0d after %0d clk",
                     tg, o.st, o.rc, o.rdy, o.flt, o.pr, o.tr, o.rr, o.cnt, cyc - last_cyc,
                     e.st, e.rc, e.rdy, e.flt, e.pr, e.tr, e.rr, e.cnt, dw);
          end
        end
        last     = o;
        last_cyc = cyc;
        first    = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    cur = '{st:3'd0, rc:2'd0, rdy:1'b0, flt:1'b0, pr:1'b1, tr:1'b1, rr:1'b1, cnt:16'd0};
    push(-1);                                   // reset values
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1. Nominal bring-up
    mode = 1; lock_ok = 1'b1;
    repeat (80) @(negedge clk);
    push_to_ready();
    enable = 1'b1;
    drain(400);
    go_idle();

    // 2. Dead refclk: three failed windows then FAULT
    mode = 0;
    repeat (80) @(negedge clk);
    cur.st = 3'd1;                  push(-1);
    cur.rc = 2'd1; cur.cnt = 16'd0; push(64);
    cur.rc = 2'd2;                  push(64);
    cur.st = 3'd7; cur.rc = 2'd3;   push(64);
    cur.flt = 1'b1;                 push(1);
    enable = 1'b1;
    drain(400);
    go_idle();

    // 3. Fast refclk (50 edges per window)
    mode = 2;
    repeat (80) @(negedge clk);
    cur.st = 3'd1;                   push(-1);
    cur.rc = 2'd1; cur.cnt = 16'd50; push(64);
    cur.rc = 2'd2;                   push(64);
    cur.st = 3'd7; cur.rc = 2'd3;    push(64);
    cur.flt = 1'b1;                  push(1);
    enable = 1'b1;
    drain(400);
    go_idle();

    // 4. No lock: three 100-clk timeouts, pll_reset pulses low three times
    mode = 1; lock_ok = 1'b0;
    repeat (80) @(negedge clk);
    cur.st = 3'd1;                   push(-1);
    cur.st = 3'd2; cur.cnt = 16'd32; push(64);
    cur.st = 3'd3;                   push(4);
    cur.pr = 1'b0;                   push(1);
    for (int i = 1; i <= 2; i++) begin
      cur.st = 3'd2; cur.rc = 2'(i); push(99);
      cur.pr = 1'b1;                 push(1);
      cur.st = 3'd3;                 push(3);
      cur.pr = 1'b0;                 push(1);
    end
    cur.st = 3'd7; cur.rc = 2'd3;    push(99);
    cur.pr = 1'b1; cur.flt = 1'b1;   push(1);
    enable = 1'b1;
    drain(800);
    go_idle();

    // 5. Lock drop in GT_WAIT, recovery through PLL_RST
    lock_ok = 1'b1;
    repeat (80) @(negedge clk);
    cur.st = 3'd1;                                push(-1);
    cur.st = 3'd2;                                push(64);
    cur.st = 3'd3;                                push(4);
    cur.pr = 1'b0;                                push(1);
    cur.st = 3'd4;                                push(-1);
    cur.st = 3'd5;                                push(4);
    cur.tr = 1'b0; cur.rr = 1'b0;                 push(1);
    cur.st = 3'd2; cur.rc = 2'd1;                 push(-1);
    cur.pr = 1'b1; cur.tr = 1'b1; cur.rr = 1'b1;  push(1);
    cur.st = 3'd3;                                push(3);
    cur.pr = 1'b0;                                push(1);
    cur.st = 3'd4;                                push(-1);
    cur.st = 3'd5;                                push(4);
    cur.tr = 1'b0; cur.rr = 1'b0;                 push(1);
    cur.st = 3'd6;                                push(-1);
    cur.rdy = 1'b1;                               push(1);
    enable = 1'b1;
    wait_for(1, 1'b0, 400);
    lock_ok = 1'b0;
    wait_for(0, 1'b1, 100);
    lock_ok = 1'b1;
    drain(600);
    go_idle();

    // 6. Refclk stops while READY
    repeat (80) @(negedge clk);
    push_to_ready();
    enable = 1'b1;
    drain(400);
    mode = 0;
`ifdef GT_SEQ_LOSS_MON_EN
    cnt_dc = 1'b1;
    cur.st = 3'd1; cur.rc = 2'd1;                                push(63);
    cur.rdy = 1'b0; cur.pr = 1'b1; cur.tr = 1'b1; cur.rr = 1'b1; push(1);
    drain(200);
`else
    repeat (150) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || state !== 3'd6) begin
      n_bad++;
      $display("FAIL ready_hold: got ready=%0b state=%0d, required ready=1 state=6", ready, state);
    end
`endif
    go_idle();

    // 7. rst asserted mid PLL_WAIT
    mode = 1; lock_ok = 1'b0;
    repeat (80) @(negedge clk);
    cnt_dc = 1'b0;
    cur.st = 3'd1;                   push(-1);
    cur.st = 3'd2; cur.cnt = 16'd32; push(64);
    cur.st = 3'd3;                   push(4);
    cur.pr = 1'b0;                   push(1);
    enable = 1'b1;
    drain(300);
    repeat (3) @(negedge clk);
    cur = '{st:3'd0, rc:2'd0, rdy:1'b0, flt:1'b0, pr:1'b1, tr:1'b1, rr:1'b1, cnt:16'd0};
    push(-1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    enable = 1'b0;
    #1;
    n_cmp++;
    if (pll_reset !== 1'b1 || gt_tx_reset !== 1'b1 || gt_rx_reset !== 1'b1 || state !== 3'd0) begin
      n_bad++;
      $display("FAIL rst_async: got resets=%b%b%b state=%0d, required resets=111 state=0",
               pll_reset, gt_tx_reset, gt_rx_reset, state);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drain(20);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
